// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared types and constants for the DDS voice and its envelope
package dds_pkg;

    localparam int ENV_LEVEL_WIDTH = 6;
    localparam int ENV_LEVEL_MAX   = 63;
    localparam int ENV_RATE_WIDTH  = 8;

    typedef enum logic [2:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } env_state_t;

    // Stages in which the level ramps and the tick prescaler runs.
    function automatic logic env_stepping(env_state_t s);
        return (s == ENV_ATTACK) || (s == ENV_DECAY) || (s == ENV_RELEASE);
    endfunction

endpackage

// File: rtl/env_rate_div.sv
// rtl/env_rate_div.sv - tick prescaler producing one step every rate+1 advances
module env_rate_div #(
    parameter int RATE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_active_low,
    input  logic                  clear,
    input  logic                  advance,
    input  logic [RATE_WIDTH-1:0] rate,
    output logic                  step
);

    logic [RATE_WIDTH-1:0] count;

    // Rate is compared live, so a new rate applies at the very next advance.
    assign step = advance && (count == rate);

    always_ff @(posedge clk or negedge rst_active_low) begin
        if (!rst_active_low) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (advance) begin
            count <= step ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/adsr_envelope.sv
// rtl/adsr_envelope.sv - per-channel ADSR envelope driving the DDS voice volume
module adsr_envelope
    import dds_pkg::*;
#(
    parameter int LEVEL_WIDTH = ENV_LEVEL_WIDTH,
    parameter int RATE_WIDTH  = ENV_RATE_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_active_low,
    input  logic                   tick,
    input  logic                   gate_in,
    input  logic [RATE_WIDTH-1:0]  attack_rate,
    input  logic [RATE_WIDTH-1:0]  decay_rate,
    input  logic [LEVEL_WIDTH-1:0] sustain_level,
    input  logic [RATE_WIDTH-1:0]  release_rate,
    output logic [LEVEL_WIDTH-1:0] vol_out,
    output logic                   env_active,
    output logic [2:0]             stage_out
);

    localparam logic [LEVEL_WIDTH-1:0] LEVEL_MAX = '1;

    env_state_t             state, state_next;
    logic [LEVEL_WIDTH-1:0] level, level_next;
    logic                   gate_q;
    logic                   rise, fall;
    logic                   clear, advance, step;
    logic [RATE_WIDTH-1:0]  rate_sel;

    assign rise    = gate_in & ~gate_q;
    assign fall    = ~gate_in & gate_q;
    assign vol_out = level;

    always_comb begin
        state_next = state;
        clear      = 1'b0;
        if (rise) begin
            state_next = ENV_ATTACK;
            clear      = 1'b1;
        end else if (fall) begin
            if (state == ENV_ATTACK || state == ENV_DECAY || state == ENV_SUSTAIN) begin
                state_next = ENV_RELEASE;
                clear      = 1'b1;
            end
        end else begin
            case (state)
                ENV_ATTACK:  if (level == LEVEL_MAX) begin
                                 state_next = ENV_DECAY;
                                 clear      = 1'b1;
                             end
                ENV_DECAY:   if (level <= sustain_level) begin
                                 state_next = ENV_SUSTAIN;
                                 clear      = 1'b1;
                             end
                ENV_RELEASE: if (level == '0) begin
                                 state_next = ENV_IDLE;
                                 clear      = 1'b1;
                             end
                default:     state_next = state;
            endcase
        end
        // Edge and stage-completion cycles never step the level.
        advance = tick && env_stepping(state) && !rise && !fall && !clear;
    end

    always_comb begin
        case (state)
            ENV_ATTACK:  rate_sel = attack_rate;
            ENV_DECAY:   rate_sel = decay_rate;
            ENV_RELEASE: rate_sel = release_rate;
            default:     rate_sel = '0;
        endcase
    end

    env_rate_div #(
        .RATE_WIDTH(RATE_WIDTH)
    ) u_rate_div (
        .clk           (clk),
        .rst_active_low(rst_active_low),
        .clear         (clear),
        .advance       (advance),
        .rate          (rate_sel),
        .step          (step)
    );

    // Completion checks run first, so a step can never pass 0, 63 or the sustain target.
    always_comb begin
        level_next = level;
        if (step) begin
            level_next = (state == ENV_ATTACK) ? level + 1'b1 : level - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_active_low) begin
        if (!rst_active_low) begin
            state      <= ENV_IDLE;
            level      <= '0;
            gate_q     <= 1'b0;
            stage_out  <= 3'd0;
            env_active <= 1'b0;
        end else begin
            gate_q     <= gate_in;
            state      <= state_next;
            level      <= level_next;
            stage_out  <= state_next;
            env_active <= (state_next != ENV_IDLE);
        end
    end

endmodule

// File: tb/tb_adsr_envelope.sv
// tb/tb_adsr_envelope.sv - scoreboard bench for adsr_envelope
module tb_adsr_envelope;

    logic       clk = 1'b0;
    logic       rst_active_low = 1'b0;
    logic       tick = 1'b0;
    logic       gate_in = 1'b0;
    logic [7:0] attack_rate = 8'd0;
    logic [7:0] decay_rate = 8'd0;
    logic [5:0] sustain_level = 6'd0;
    logic [7:0] release_rate = 8'd0;
    logic [5:0] vol_out;
    logic       env_active;
    logic [2:0] stage_out;

    typedef struct {
        int vol;
        int stg;
        int act;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    int m_state = 0;
    int m_level = 0;
    int m_pre   = 0;
    int m_gq    = 0;

    adsr_envelope dut (
        .clk           (clk),
        .rst_active_low(rst_active_low),
        .tick          (tick),
        .gate_in       (gate_in),
        .attack_rate   (attack_rate),
        .decay_rate    (decay_rate),
        .sustain_level (sustain_level),
        .release_rate  (release_rate),
        .vol_out       (vol_out),
        .env_active    (env_active),
        .stage_out     (stage_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Behavioural reference: one clock of the envelope with the current inputs.
    task automatic model(input int t, input int g);
        int rise, fall, rate;
        rise = (g == 1 && m_gq == 0);
        fall = (g == 0 && m_gq == 1);
        m_gq = g;
        rate = (m_state == 1) ? int'(attack_rate) :
               (m_state == 2) ? int'(decay_rate)  :
               (m_state == 4) ? int'(release_rate) : 0;
        if (rise) begin
            m_state = 1; m_pre = 0;
        end else if (fall) begin
            if (m_state >= 1 && m_state <= 3) begin
                m_state = 4; m_pre = 0;
            end
        end else if (m_state == 1 && m_level == 63) begin
            m_state = 2; m_pre = 0;
        end else if (m_state == 2 && m_level <= int'(sustain_level)) begin
            m_state = 3; m_pre = 0;
        end else if (m_state == 4 && m_level == 0) begin
            m_state = 0; m_pre = 0;
        end else if (t == 1 && (m_state == 1 || m_state == 2 || m_state == 4)) begin
            if (m_pre == rate) begin
                m_pre = 0;
                m_level = (m_state == 1) ? m_level + 1 : m_level - 1;
            end else begin
                m_pre = m_pre + 1;
            end
        end
    endtask

    task automatic step(input int t, input int g);
        exp_t e;
        tick    = t[0];
        gate_in = g[0];
        model(t, g);
        sb.push_back('{vol: m_level, stg: m_state, act: (m_state != 0) ? 1 : 0});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("sb_vol", vol_out, e.vol);
        chk("sb_stage", stage_out, e.stg);
        chk("sb_active", env_active, e.act);
    endtask

    initial begin
        @(posedge clk);
        #1;
        chk("reset_vol", vol_out, 0);
        chk("reset_stage", stage_out, 0);
        chk("reset_active", env_active, 0);
        #2 rst_active_low = 1'b1;

        attack_rate   = 8'd0;
        decay_rate    = 8'd1;
        sustain_level = 6'd32;
        release_rate  = 8'd3;
        step(1, 1);
        chk("rise_stage", stage_out, 1);
        repeat (63) step(1, 1);
        chk("attack_peak", vol_out, 63);
        step(1, 1);
        chk("decay_enter", stage_out, 2);
        repeat (62) step(1, 1);
        chk("decay_floor", vol_out, 32);
        step(1, 1);
        chk("sustain_enter", stage_out, 3);
        sustain_level = 6'd10;
        repeat (10) step(1, 1);
        chk("sustain_hold", vol_out, 32);

        step(1, 0);
        chk("release_enter", stage_out, 4);
        repeat (128) step(1, 0);
        chk("release_zero", vol_out, 0);
        step(1, 0);
        chk("release_idle", stage_out, 0);
        chk("release_inactive", env_active, 0);

        step(1, 1);
        repeat (20) step(1, 1);
        chk("pre_retrig_vol", vol_out, 20);
        step(1, 0);
        repeat (2) step(1, 0);
        attack_rate = 8'd3;
        step(1, 1);
        chk("retrig_stage", stage_out, 1);
        chk("retrig_vol", vol_out, 20);
        repeat (3) step(1, 1);
        chk("retrig_prescale", vol_out, 20);
        step(1, 1);
        chk("retrig_step", vol_out, 21);

        release_rate = 8'd0;
        step(1, 0);
        for (int i = 0; i < 100 && m_state != 0; i++) step(1, 0);
        chk("to_idle_1", stage_out, 0);

        step(0, 1);
        chk("pulse_attack", stage_out, 1);
        step(0, 1);
        step(0, 0);
        chk("pulse_release", stage_out, 4);
        chk("pulse_vol", vol_out, 0);
        step(0, 0);
        chk("pulse_idle", stage_out, 0);

        sustain_level = 6'd63;
        attack_rate   = 8'd0;
        step(1, 1);
        repeat (63) step(1, 1);
        step(1, 1);
        chk("sus63_decay", stage_out, 2);
        step(1, 1);
        chk("sus63_sustain", stage_out, 3);
        chk("sus63_vol", vol_out, 63);

        step(1, 0);
        for (int i = 0; i < 100 && m_state != 0; i++) step(1, 0);
        chk("to_idle_2", stage_out, 0);

        step(1, 1);
        repeat (40) step(1, 1);
        chk("pre_reset_vol", vol_out, 40);
        #2 rst_active_low = 1'b0;
        #1;
        chk("async_vol", vol_out, 0);
        chk("async_stage", stage_out, 0);
        chk("async_active", env_active, 0);
        m_state = 0; m_level = 0; m_pre = 0; m_gq = 0;
        @(posedge clk);
        #1;
        chk("held_reset_vol", vol_out, 0);
        #1 rst_active_low = 1'b1;
        step(0, 1);
        chk("post_reset_stage", stage_out, 1);
        chk("post_reset_vol", vol_out, 0);
        step(1, 1);
        chk("post_reset_step", vol_out, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
